// File: rtl/imem_loader.sv
// Instruction-memory loader for the Y86 pipeline: streams bytes into a 256-byte
// memory from a programmed base and exposes the 10-byte fetch window.
module imem_loader #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   byte_count,
  output logic [7:0]        checksum,
  input  logic [63:0]       rd_pc,
  output logic [79:0]       rd_instr,
  output logic              rd_mem_error
);

  localparam int                WIN_BYTES = 10;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        mem [MEM_BYTES];
  logic              xfer;
  logic              start;
  logic              at_last;

  assign xfer    = in_valid && in_ready;
  assign start   = load_start && (state != LOAD);
  assign at_last = (wr_addr == LAST_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (load_start) state_nxt = LOAD;
      LOAD:       if (xfer && (in_last || at_last)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      LOAD:    begin in_ready = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The address saturates at the top of memory; a full image without in_last
  // flags overflow instead of wrapping onto the start of the program.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr      <= '0;
      byte_count   <= '0;
      checksum     <= '0;
      overflow_err <= 1'b0;
    end else if (start) begin
      wr_addr      <= load_base;
      byte_count   <= '0;
      checksum     <= '0;
      overflow_err <= 1'b0;
    end else if (xfer) begin
      if (!at_last) wr_addr <= wr_addr + ADDR_W'(1);
      byte_count <= byte_count + (ADDR_W+1)'(1);
      checksum   <= checksum + in_byte;
      if (at_last && !in_last) overflow_err <= 1'b1;
    end
  end

  // NOTE: the memory array has no reset; loaded programs survive rst_n and
  // the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_addr] <= in_byte;
  end

  assign rd_mem_error = (rd_pc >= 64'(MEM_BYTES));

  // Bytes beyond the end of memory read as zero; the window never wraps.
  always_comb begin
    rd_instr = '0;
    if (!rd_mem_error) begin
      for (int k = 0; k < WIN_BYTES; k++) begin
        if (({1'b0, rd_pc[ADDR_W-1:0]} + (ADDR_W+1)'(k)) < (ADDR_W+1)'(MEM_BYTES))
          rd_instr[8*(WIN_BYTES-1-k) +: 8] = mem[rd_pc[ADDR_W-1:0] + ADDR_W'(k)];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: reset, basic load, gapped load,
// overflow, read-window boundaries and reset in the middle of a load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  load_base;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        busy;
  logic        done;
  logic        overflow_err;
  logic [8:0]  byte_count;
  logic [7:0]  checksum;
  logic [63:0] rd_pc;
  logic [79:0] rd_instr;
  logic        rd_mem_error;

  int errors = 0;
  int checks = 0;

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_base    (load_base),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .in_last      (in_last),
    .busy         (busy),
    .done         (done),
    .overflow_err (overflow_err),
    .byte_count   (byte_count),
    .checksum     (checksum),
    .rd_pc        (rd_pc),
    .rd_instr     (rd_instr),
    .rd_mem_error (rd_mem_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] actual, input logic [79:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic start_load(input logic [7:0] base);
    load_start = 1'b1;
    load_base  = base;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input bit chk_busy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (chk_busy) check("gap_busy", 80'(busy), 80'(1));
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic ovf,
                              input logic [8:0] cnt, input logic [7:0] cs);
    check({tag, "_done"}, 80'(done), 80'(d));
    check({tag, "_ovf"},  80'(overflow_err), 80'(ovf));
    check({tag, "_cnt"},  80'(byte_count), 80'(cnt));
    check({tag, "_csum"}, 80'(checksum), 80'(cs));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img [5];
    img[0] = 8'h40; img[1] = 8'h54; img[2] = 8'h00; img[3] = 8'h00; img[4] = 8'h01;

    rst_n = 1'b0; load_start = 1'b0; load_base = '0;
    in_valid = 1'b0; in_byte = '0; in_last = 1'b0; rd_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 80'(in_ready), 80'(0));
    check("rst_busy",  80'(busy), 80'(0));
    check_status("rst", 1'b0, 1'b0, 9'd0, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 80'(busy), 80'(0));

    // Basic load at base 4.
    start_load(8'd4);
    check("load_busy",  80'(busy), 80'(1));
    check("load_ready", 80'(in_ready), 80'(1));
    rd_pc = 64'd4;
    send(img[0], 1'b0);
    check("first_byte_visible", 80'(rd_instr[79:72]), 80'(8'h40));
    for (int i = 1; i < 5; i++) send(img[i], i == 4);
    check_status("basic", 1'b1, 1'b0, 9'd5, 8'h95);
    check("basic_ready", 80'(in_ready), 80'(0));
    check("basic_busy",  80'(busy), 80'(0));
    check("basic_read",  80'(rd_instr[79:40]), 80'(40'h40_54_00_00_01));
    check("basic_rderr", 80'(rd_mem_error), 80'(0));
    idle_cycles(2, 1'b0);
    check_status("basic_hold", 1'b1, 1'b0, 9'd5, 8'h95);

    // Same image with 3-cycle gaps at base 20; a load_start during LOAD is ignored.
    start_load(8'd20);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        load_start = 1'b1;
        load_base  = 8'd100;
      end
      send(img[i], i == 4);
      load_start = 1'b0;
      if (i < 4) idle_cycles(3, 1'b1);
    end
    check_status("gap", 1'b1, 1'b0, 9'd5, 8'h95);
    rd_pc = 64'd20; #1;
    check("gap_read", 80'(rd_instr[79:40]), 80'(40'h40_54_00_00_01));

    // Overflow: base 250, bytes 01..07 with no last.
    start_load(8'd250);
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    check_status("ovf", 1'b1, 1'b1, 9'd6, 8'h15);
    check("ovf_ready", 80'(in_ready), 80'(0));
    send(8'h07, 1'b0);
    check_status("ovf_7th", 1'b1, 1'b1, 9'd6, 8'h15);

    // Read window boundaries.
    rd_pc = 64'd250; #1;
    check("rd_250",     rd_instr, 80'h01_02_03_04_05_06_00_00_00_00);
    check("rd_250_err", 80'(rd_mem_error), 80'(0));
    rd_pc = 64'd255; #1;
    check("rd_255",     rd_instr, 80'h06_00_00_00_00_00_00_00_00_00);
    rd_pc = 64'd256; #1;
    check("rd_256",     rd_instr, 80'h0);
    check("rd_256_err", 80'(rd_mem_error), 80'(1));
    rd_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    check("rd_top",     rd_instr, 80'h0);
    check("rd_top_err", 80'(rd_mem_error), 80'(1));
    @(posedge clk); #1;

    // Reset mid-load after 3 of 5 bytes, asserted between clock edges.
    start_load(8'd40);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  80'(busy), 80'(0));
    check("mid_rst_ready", 80'(in_ready), 80'(0));
    check_status("mid_rst", 1'b0, 1'b0, 9'd0, 8'h00);
    rd_pc = 64'd40; #1;
    check("mid_rst_keep", 80'(rd_instr[79:56]), 80'(24'hAA_BB_CC));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 80'(busy), 80'(0));

    start_load(8'd60);
    check_status("restart", 1'b0, 1'b0, 9'd0, 8'h00);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    check_status("restart_end", 1'b1, 1'b0, 9'd2, 8'h33);
    rd_pc = 64'd60; #1;
    check("restart_read", 80'(rd_instr[79:64]), 80'(16'h11_22));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory writer for the Y86 pipeline. Accepts a byte stream over a valid/ready handshake, writes it into a 256-byte instruction memory starting at a programmed base address, and reports completion, byte count, checksum and overflow. It also exposes the combinational 10-byte read window that the fetch stage consumes, so fetch reads exactly what the loader wrote.

## Interface
- MEM_BYTES, 256, instruction memory size in bytes (byte addresses 0..MEM_BYTES-1)
- ADDR_W, 8, width of the write address and base address (log2 MEM_BYTES)

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- load_start  input  1  one-cycle request to begin a load
- load_base  input  ADDR_W  first write address, sampled with load_start
- in_valid  input  1  in_byte/in_last valid
- in_ready  output  1  loader can accept a byte
- in_byte  input  8  instruction byte
- in_last  input  1  marks the final byte of the image
- busy  output  1  load in progress
- done  output  1  load finished; held until the next load_start
- overflow_err  output  1  image ran past the last address without in_last
- byte_count  output  ADDR_W+1  bytes accepted in the current or last load
- checksum  output  8  sum of accepted bytes, modulo 256
- rd_pc  input  64  fetch PC
- rd_instr  output  80  bytes rd_pc..rd_pc+9; byte at rd_pc in bits 79:72
- rd_mem_error  output  1  rd_pc >= MEM_BYTES

## Operation
- States: IDLE, LOAD, DONE. Reset enters IDLE.
- IDLE or DONE, load_start=1: next state LOAD. Write address is set to load_base. byte_count, checksum, done and overflow_err are cleared.
- LOAD: in_ready=1. load_start is ignored.
- Transfer occurs when in_valid && in_ready. On a transfer:
  - mem[addr] <= in_byte
  - addr increments
  - byte_count increments
  - checksum <= checksum + in_byte (8-bit wrap)
- Transfer with in_last=1: next state DONE, done=1.
- Transfer at addr = MEM_BYTES-1 with in_last=0: the byte is written, then next state DONE with done=1 and overflow_err=1. The write address never wraps.
- DONE: in_ready=0. done, overflow_err, byte_count and checksum are held.
- busy = (state == LOAD). done = (state == DONE).
- Read port is purely combinational:
  - Each byte k (0..9) = mem[rd_pc+k] if rd_pc+k < MEM_BYTES, otherwise 8'h00. Reads never wrap.
  - rd_mem_error = (rd_pc >= MEM_BYTES). When it is set, rd_instr = 0.
  - 64-bit address arithmetic, so there is no overflow for rd_pc near 2^64.
- Memory contents are not affected by reset. Contents are undefined until written.

## Timing
- Reset values: in_ready=0, busy=0, done=0, overflow_err=0, byte_count=0, checksum=0. State IDLE, write address 0.
- Reset applies asynchronously on rst_n falling. The first state change occurs on the first clk rising edge with rst_n=1.
- load_start sampled at edge N: busy and in_ready are high after edge N.
- A byte accepted at edge N is visible on rd_instr after edge N. A same-cycle read of that address returns the old value.
- The last byte accepted at edge N: done=1 and in_ready=0 after edge N. Throughput is one byte per cycle.
- in_valid may drop at any cycle. No transfer occurs and all state holds.
- Reset mid-load: immediate return to IDLE with all outputs at their reset values. Bytes already written are kept.
- load_start and a transfer in the same cycle in LOAD: the transfer proceeds and load_start is ignored.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all status outputs are 0 immediately, with no clock edge needed.
- Basic load: load_start with base=4, then 40 54 00 00 01, last on the 5th byte. Required response:
  - done=1 one cycle after the last transfer
  - byte_count=5, checksum=8'h95
  - rd_pc=4 -> rd_instr[79:40]=40_54_00_00_01
  - overflow_err=0
- Backpressure/gaps: the same image with in_valid low for 3 cycles between each byte -> identical final memory, count and checksum. busy stays high throughout.
- Overflow: base=250, send 7 bytes 01..07 without last. Required response:
  - 6 bytes accepted
  - overflow_err=1, done=1, byte_count=6, checksum=8'h15, in_ready=0
  - the 7th byte is not accepted
- Read boundaries:
  - rd_pc=250 -> bytes 250..255 followed by four 00 bytes, rd_mem_error=0
  - rd_pc=256 -> rd_mem_error=1, rd_instr=0
- Reset mid-load: reset after 3 of 5 bytes -> IDLE with count 0. The 3 written bytes are still readable. A new load_start restarts cleanly with count and checksum from 0.
